// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan controller.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // Counter width for a 0..range-1 count, never narrower than one bit.
    function automatic int cnt_w(input int range);
        return (range > 32'sd1) ? $clog2(range) : 32'sd1;
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// Hex-to-seven-segment decoder, active-low, bit order {g,f,e,d,c,b,a}.
module bcd7seg (
    input  logic [3:0] bcd,
    input  logic       unused_tie,
    output logic [6:0] seg
);

    // Segment lookup for digits 0-9 and A-F.
    always_comb begin
        seg = 7'h7F;
        case (bcd)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit display controller: per-digit register file, one shared decoder
// refreshed round-robin, global blink phase and an eight-cycle clear sequence.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_PASSES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_clr,
    input  logic [2:0] wr_idx,
    input  logic [3:0] wr_data,
    input  logic       wr_blank,
    input  logic       wr_blink,
    output logic [6:0] h0,
    output logic [6:0] h1,
    output logic [6:0] h2,
    output logic [6:0] h3,
    output logic [6:0] h4,
    output logic [6:0] h5,
    output logic [6:0] h6,
    output logic [6:0] h7
);

    localparam int PW = cnt_w(SCAN_DIV);
    localparam int BW = cnt_w(BLINK_PASSES);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] PASS_MAX  = BW'(BLINK_PASSES - 1);

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [2:0]              clr_idx_r;
    logic                    wr_ready_r;
    logic                    ent_wr_s;
    logic                    clr_wr_s;

    logic [3:0]              data_r  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_r;
    logic [NUM_DIGITS-1:0]   blink_r;

    logic [PW-1:0]           presc_r;
    logic [2:0]              scan_idx_r;
    logic [BW-1:0]           pass_cnt_r;
    logic                    blink_phase_r;
    logic                    tick_s;
    logic [3:0]              scan_data_s;
    logic [6:0]              dec_seg_s;
    logic [6:0]              scan_seg_s;
    logic [6:0]              h_r     [NUM_DIGITS];

    // Next-state and write-enable decode for the RUN/CLEAR controller.
    always_comb begin
        state_nxt_s = state_r;
        ent_wr_s    = 1'b0;
        clr_wr_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (wr_valid) begin
                    if (wr_clr) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        ent_wr_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_CLEAR: begin
                clr_wr_s = 1'b1;
                if (clr_idx_r == 3'd7) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // FSM state, clear pointer and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            clr_idx_r  <= 3'd0;
            wr_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            wr_ready_r <= (state_nxt_s == ST_RUN);
            if (state_r == ST_CLEAR) begin
                clr_idx_r <= clr_idx_r + 3'd1;
            end else begin
                clr_idx_r <= 3'd0;
            end
        end
    end

    // Per-digit register file: requester writes in RUN, sequential wipe in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                data_r[i] <= 4'h0;
            end
            blank_r <= {NUM_DIGITS{1'b1}};
            blink_r <= {NUM_DIGITS{1'b0}};
        end else if (ent_wr_s) begin
            data_r[wr_idx]  <= wr_data;
            blank_r[wr_idx] <= wr_blank;
            blink_r[wr_idx] <= wr_blink;
        end else if (clr_wr_s) begin
            data_r[clr_idx_r]  <= 4'h0;
            blank_r[clr_idx_r] <= 1'b1;
            blink_r[clr_idx_r] <= 1'b0;
        end else begin
            blank_r <= blank_r;
        end
    end

    assign tick_s      = (presc_r == PRESC_MAX);
    assign scan_data_s = data_r[scan_idx_r];

    bcd7seg u_dec (
        .bcd        (scan_data_s),
        .unused_tie (1'b0),
        .seg        (dec_seg_s)
    );

    // Blank/blink override in front of the output latch.
    always_comb begin
        scan_seg_s = dec_seg_s;
        if (blank_r[scan_idx_r] || (blink_r[scan_idx_r] && blink_phase_r)) begin
            scan_seg_s = SEG_OFF;
        end else begin
            scan_seg_s = dec_seg_s;
        end
    end

    // Prescaler, scan pointer, pass counter, blink phase and digit latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r       <= '0;
            scan_idx_r    <= 3'd0;
            pass_cnt_r    <= '0;
            blink_phase_r <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                h_r[i] <= SEG_OFF;
            end
        end else if (tick_s) begin
            presc_r         <= '0;
            h_r[scan_idx_r] <= scan_seg_s;
            scan_idx_r      <= scan_idx_r + 3'd1;
            if (scan_idx_r == 3'd7) begin
                if (pass_cnt_r == PASS_MAX) begin
                    pass_cnt_r    <= '0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    pass_cnt_r <= pass_cnt_r + BW'(1);
                end
            end else begin
                pass_cnt_r <= pass_cnt_r;
            end
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    assign wr_ready = wr_ready_r;
    assign h0 = h_r[0];
    assign h1 = h_r[1];
    assign h2 = h_r[2];
    assign h3 = h_r[3];
    assign h4 = h_r[4];
    assign h5 = h_r[5];
    assign h6 = h_r[6];
    assign h7 = h_r[7];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random writes,
// compared every cycle against a cycle-count based reference model.
module tb_seg_scan_ctrl;

    localparam int SD = 2;
    localparam int BP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_clr = 1'b0;
    logic [2:0] wr_idx = 3'd0;
    logic [3:0] wr_data = 4'h0;
    logic       wr_blank = 1'b0;
    logic       wr_blink = 1'b0;
    logic [6:0] h0, h1, h2, h3, h4, h5, h6, h7;
    logic [6:0] hv [8];

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] m_data  [8];
    logic       m_blank [8];
    logic       m_blink [8];
    logic [6:0] m_h     [8];
    bit         m_clr;
    int         m_cnt;
    int         m_cyc;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLINK_PASSES(BP)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_clr(wr_clr), .wr_idx(wr_idx), .wr_data(wr_data),
        .wr_blank(wr_blank), .wr_blink(wr_blink),
        .h0(h0), .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5), .h6(h6), .h7(h7)
    );

    assign hv[0] = h0; assign hv[1] = h1; assign hv[2] = h2; assign hv[3] = h3;
    assign hv[4] = h4; assign hv[5] = h5; assign hv[6] = h6; assign hv[7] = h7;

    always #5 clk = ~clk;

    function automatic logic [55:0] pack_dut();
        return {h7, h6, h5, h4, h3, h2, h1, h0};
    endfunction

    function automatic logic [55:0] pack_model();
        logic [55:0] v;
        for (int i = 0; i < 8; i++) v[i*7 +: 7] = m_h[i];
        return v;
    endfunction

    // One clock: advance the model on the edge, compare everything on the falling edge.
    task automatic cycle();
        int  k;
        int  d;
        bit  phase;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_data[i] = 4'h0; m_blank[i] = 1'b1; m_blink[i] = 1'b0; m_h[i] = 7'h7F;
            end
            m_clr = 1'b0; m_cnt = 0; m_cyc = 0;
        end else begin
            k = m_cyc / SD;
            d = k % 8;
            phase = ((k / (8 * BP)) % 2) == 1;
            if ((m_cyc % SD) == SD - 1)
                m_h[d] = (m_blank[d] || (m_blink[d] && phase)) ? 7'h7F : seg_tab[m_data[d]];
            if (!m_clr) begin
                if (wr_valid && wr_clr) begin
                    m_clr = 1'b1; m_cnt = 0;
                end else if (wr_valid) begin
                    m_data[wr_idx] = wr_data; m_blank[wr_idx] = wr_blank; m_blink[wr_idx] = wr_blink;
                end
            end else begin
                m_data[m_cnt] = 4'h0; m_blank[m_cnt] = 1'b1; m_blink[m_cnt] = 1'b0;
                m_cnt++;
                if (m_cnt == 8) m_clr = 1'b0;
            end
            m_cyc++;
        end
        @(negedge clk);
        checks++;
        if (pack_dut() !== pack_model() || wr_ready !== !m_clr) begin
            failures++;
            $display("FAIL cycle_model t=%0t h=%h ready=%b expected h=%h ready=%b",
                     $time, pack_dut(), wr_ready, pack_model(), !m_clr);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_write(input logic [2:0] idx, input logic [3:0] data,
                            input logic blank, input logic blink);
        bit pre;
        bit done = 1'b0;
        wr_idx = idx; wr_data = data; wr_blank = blank; wr_blink = blink;
        wr_clr = 1'b0; wr_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            pre = !m_clr;
            cycle();
            done = pre;
        end
        wr_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL write_timeout idx=%0d not accepted within 20 cycles", idx);
        end
    endtask

    task automatic do_clear();
        wr_clr = 1'b1; wr_valid = 1'b1;
        cycle();
        wr_clr = 1'b0; wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit quiet = 1'b1;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        checks++;
        if (pack_dut() !== {8{7'h7F}} || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state h=%h ready=%b expected h=%h ready=1", pack_dut(), wr_ready, {8{7'h7F}});
        end
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (pack_dut() !== {8{7'h7F}}) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL reset_quiet outputs changed=1 expected changed=0");
        end
    endtask

    task automatic test_basic_write();
        do_write(3'd0, 4'h3, 1'b0, 1'b0);
        run(8 * SD);
        checks++;
        if (h0 !== 7'b0110000 || {h7, h6, h5, h4, h3, h2, h1} !== {7{7'h7F}}) begin
            failures++;
            $display("FAIL basic_write h=%h expected h0=30 others=7f", pack_dut());
        end
    endtask

    task automatic test_blink();
        logic [6:0] prev;
        int last = -1;
        int nchg = 0;
        bit bad_val = 1'b0;
        bit bad_gap = 1'b0;
        do_write(3'd7, 4'hF, 1'b0, 1'b1);
        prev = h7;
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (h7 !== prev) begin
                if (h7 !== 7'b0001110 && h7 !== 7'h7F) bad_val = 1'b1;
                if (nchg >= 2 && (c - last) != BP * 8 * SD) bad_gap = 1'b1;
                last = c; nchg++; prev = h7;
            end
        end
        checks++;
        if (bad_val || bad_gap || nchg < 5) begin
            failures++;
            $display("FAIL blink changes=%0d bad_val=%b bad_gap=%b expected changes>=5 every %0d cycles",
                     nchg, bad_val, bad_gap, BP * 8 * SD);
        end
    endtask

    task automatic test_clear();
        int lows = 0;
        int n = 0;
        bit pre;
        bit done = 1'b0;
        for (int i = 0; i < 8; i++) do_write(3'(i), 4'h8, 1'b0, 1'b0);
        run(8 * SD);
        checks++;
        if (pack_dut() !== {8{7'h00}}) begin
            failures++;
            $display("FAIL clear_preload h=%h expected %h", pack_dut(), {8{7'h00}});
        end
        do_clear();
        wr_idx = 3'd2; wr_data = 4'h5; wr_blank = 1'b0; wr_blink = 1'b0; wr_valid = 1'b1;
        while (n < 20 && !done) begin
            if (wr_ready === 1'b0) lows++;
            pre = !m_clr;
            n++;
            cycle();
            done = pre;
        end
        wr_valid = 1'b0;
        checks++;
        if (lows != 8 || n != 9) begin
            failures++;
            $display("FAIL clear_stall ready_low=%0d accept_cycle=%0d expected 8 and 9", lows, n);
        end
        run(8 * SD);
        checks++;
        if (h2 !== 7'b0010010 || {h7, h6, h5, h4, h3, h1, h0} !== {7{7'h7F}}) begin
            failures++;
            $display("FAIL clear_result h=%h expected h2=12 others=7f", pack_dut());
        end
    endtask

    task automatic test_collision();
        int k = $urandom_range(0, 7);
        bit found = 1'b0;
        do_write(3'(k), 4'h0, 1'b0, 1'b0);
        run(8 * SD);
        for (int i = 0; i < 8 * SD + 1 && !found; i++) begin
            if ((m_cyc % SD) == SD - 1 && ((m_cyc / SD) % 8) == k) found = 1'b1;
            else cycle();
        end
        wr_idx = 3'(k); wr_data = 4'h1; wr_blank = 1'b0; wr_blink = 1'b0; wr_valid = 1'b1;
        cycle();
        wr_valid = 1'b0;
        checks++;
        if (!found || hv[k] !== 7'b1000000) begin
            failures++;
            $display("FAIL collision_now digit=%0d h=%h found=%b expected 40", k, hv[k], found);
        end
        run(8 * SD - 1);
        checks++;
        if (hv[k] !== 7'b1000000) begin
            failures++;
            $display("FAIL collision_hold digit=%0d h=%h expected 40", k, hv[k]);
        end
        cycle();
        checks++;
        if (hv[k] !== 7'b1111001) begin
            failures++;
            $display("FAIL collision_next digit=%0d h=%h expected 79", k, hv[k]);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit blank_ok = 1'b1;
        for (int i = 0; i < 8; i++) do_write(3'(i), 4'(i + 2), 1'b0, 1'b0);
        run(8 * SD);
        do_clear();
        run(3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (wr_ready !== 1'b1 || pack_dut() !== {8{7'h7F}}) begin
            failures++;
            $display("FAIL reset_mid_clear h=%h ready=%b expected h=%h ready=1", pack_dut(), wr_ready, {8{7'h7F}});
        end
        for (int i = 0; i < 8 * SD; i++) begin
            cycle();
            if (pack_dut() !== {8{7'h7F}}) blank_ok = 1'b0;
        end
        checks++;
        if (!blank_ok) begin
            failures++;
            $display("FAIL reset_entries_blank blank=0 expected blank=1");
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8)
                do_write(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                         1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
            else if (r == 19 && $urandom_range(0, 2) == 0)
                do_clear();
            else
                cycle();
        end
        run(8 * SD * 2);
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_blink();
        test_clear();
        test_collision();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
